// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the pixel source: FSM states, error codes, pattern modes
// and the word generator used by the producer.
package painterengine_gpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam logic [2:0] ERR_OK      = 3'd0;
  localparam logic [2:0] ERR_PARAM   = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_MODE    = 3'd3;

  localparam logic [1:0] MODE_SOLID    = 2'd0;
  localparam logic [1:0] MODE_CHECKER  = 2'd1;
  localparam logic [1:0] MODE_RAMP     = 2'd2;
  localparam logic [1:0] MODE_RESERVED = 2'd3;

  // Stall limit for a consumer that holds valid data without popping
  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

  // Word for index idx: checker alternates every 8 words, ramp wraps mod 2^32
  function automatic logic [31:0] pattern_word(input logic [1:0]  mode,
                                               input logic [31:0] color0,
                                               input logic [31:0] color1,
                                               input logic [31:0] idx);
    logic [31:0] word;
    case (mode)
      MODE_CHECKER: word = idx[3] ? color1 : color0;
      MODE_RAMP:    word = color0 + idx;
      default:      word = color0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; the head reads as zero when empty.
module painterengine_gpu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_wire_clock,
  input  logic                     i_wire_reset,
  input  logic                     i_wire_push,
  input  logic                     i_wire_pop,
  input  logic                     i_wire_flush,
  input  logic [WIDTH-1:0]         i_wire_data,
  output logic [WIDTH-1:0]         o_wire_data,
  output logic                     o_wire_full,
  output logic                     o_wire_empty,
  output logic [$clog2(DEPTH):0]   o_wire_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_eff, pop_eff;

  assign o_wire_full  = (count_reg == CNT_W'(DEPTH));
  assign o_wire_empty = (count_reg == '0);
  assign o_wire_count = count_reg;
  assign o_wire_data  = o_wire_empty ? '0 : mem_reg[rd_ptr_reg];

  // Pops on an empty FIFO are dropped; a push into a full FIFO is allowed only alongside a pop
  assign pop_eff  = i_wire_pop && !o_wire_empty;
  assign push_eff = i_wire_push && (!o_wire_full || pop_eff);

  // Storage entries: each captures the incoming word when the write pointer selects it
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge i_wire_clock) begin
        if (push_eff && (wr_ptr_reg == AW'(gi)))
          mem_reg[gi] <= i_wire_data;
      end
    end
  endgenerate

  // Pointer and occupancy bookkeeping; flush discards everything
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset || i_wire_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/painterengine_gpu_pixel_source.sv
// Pattern generator that streams solid / checker / ramp words into a FIFO read by a DMA writer.
module painterengine_gpu_pixel_source
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_FIFO_DEPTH = 4
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_start,
  input  logic        i_wire_clear,
  input  logic [1:0]  i_wire_mode,
  input  logic [31:0] i_wire_color0,
  input  logic [31:0] i_wire_color1,
  input  logic [31:0] i_wire_length,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic        o_wire_busy,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [2:0]  o_wire_error_type
);

  localparam int CNT_W = $clog2(PARAM_FIFO_DEPTH) + 1;

  state_t      state_reg, state_next;
  logic [1:0]  mode_reg, mode_next;
  logic [31:0] color0_reg, color0_next;
  logic [31:0] color1_reg, color1_next;
  logic [31:0] length_reg, length_next;
  logic [31:0] index_reg, index_next;
  logic [15:0] timeout_reg, timeout_next;
  logic [2:0]  error_type_reg, error_type_next;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      push_word;

  assign fifo_pop  = i_wire_data_next && !fifo_empty;
  assign push_word = pattern_word(mode_reg, color0_reg, color1_reg, index_reg);

  painterengine_gpu_sync_fifo #(
    .WIDTH(32),
    .DEPTH(PARAM_FIFO_DEPTH)
  ) u_fifo (
    .i_wire_clock (i_wire_clock),
    .i_wire_reset (i_wire_reset),
    .i_wire_push  (fifo_push),
    .i_wire_pop   (fifo_pop),
    .i_wire_flush (fifo_flush),
    .i_wire_data  (push_word),
    .o_wire_data  (o_wire_data),
    .o_wire_full  (fifo_full),
    .o_wire_empty (fifo_empty),
    .o_wire_count (fifo_count)
  );

  // Job state and latched parameters
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= MODE_SOLID;
      color0_reg     <= '0;
      color1_reg     <= '0;
      length_reg     <= '0;
      index_reg      <= '0;
      timeout_reg    <= '0;
      error_type_reg <= ERR_OK;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_next;
      color0_reg     <= color0_next;
      color1_reg     <= color1_next;
      length_reg     <= length_next;
      index_reg      <= index_next;
      timeout_reg    <= timeout_next;
      error_type_reg <= error_type_next;
    end
  end

  // Next-state, producer push and consumer-stall watchdog
  always_comb begin
    state_next      = state_reg;
    mode_next       = mode_reg;
    color0_next     = color0_reg;
    color1_next     = color1_reg;
    length_next     = length_reg;
    index_next      = index_reg;
    timeout_next    = timeout_reg;
    error_type_next = error_type_reg;
    fifo_push       = 1'b0;
    fifo_flush      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_wire_start) begin
          mode_next    = i_wire_mode;
          color0_next  = i_wire_color0;
          color1_next  = i_wire_color1;
          length_next  = i_wire_length;
          index_next   = '0;
          timeout_next = '0;
          // A zero-length job is reported ahead of an unsupported mode
          if (i_wire_length == '0) begin
            state_next      = ST_ERROR;
            error_type_next = ERR_PARAM;
          end else if (i_wire_mode == MODE_RESERVED) begin
            state_next      = ST_ERROR;
            error_type_next = ERR_MODE;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!fifo_full || fifo_pop) begin
          fifo_push  = 1'b1;
          index_next = index_reg + 32'd1;
          if (index_reg == length_reg - 32'd1)
            state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && (fifo_count == CNT_W'(1)))
          state_next = ST_DONE;
      end
      ST_DONE, ST_ERROR: begin
        if (i_wire_clear) begin
          fifo_flush      = 1'b1;
          state_next      = ST_IDLE;
          error_type_next = ERR_OK;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The watchdog overrides normal progress once the consumer has stalled too long
    if (fifo_pop) begin
      timeout_next = '0;
    end else if (((state_reg == ST_RUN) || (state_reg == ST_DRAIN)) && !fifo_empty) begin
      timeout_next = timeout_reg + 16'd1;
      if (timeout_reg == TIMEOUT_LIMIT - 16'd1) begin
        state_next      = ST_ERROR;
        error_type_next = ERR_TIMEOUT;
        fifo_push       = 1'b0;
        index_next      = index_reg;
      end
    end
  end

  assign o_wire_data_valid = !fifo_empty;
  assign o_wire_busy       = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign o_wire_done       = (state_reg == ST_DONE);
  assign o_wire_error      = (state_reg == ST_ERROR);
  assign o_wire_error_type = error_type_reg;

endmodule

// File: tb/tb_painterengine_gpu_pixel_source.sv
// Directed self-checking bench for painterengine_gpu_pixel_source.
module tb_painterengine_gpu_pixel_source;

  logic        i_wire_clock = 1'b0;
  logic        i_wire_reset;
  logic        i_wire_start;
  logic        i_wire_clear;
  logic [1:0]  i_wire_mode;
  logic [31:0] i_wire_color0;
  logic [31:0] i_wire_color1;
  logic [31:0] i_wire_length;
  logic [31:0] o_wire_data;
  logic        o_wire_data_valid;
  logic        i_wire_data_next;
  logic        o_wire_busy;
  logic        o_wire_done;
  logic        o_wire_error;
  logic [2:0]  o_wire_error_type;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] got_words [64];
  int          got_n;

  painterengine_gpu_pixel_source #(.PARAM_FIFO_DEPTH(4)) dut (
    .i_wire_clock      (i_wire_clock),
    .i_wire_reset      (i_wire_reset),
    .i_wire_start      (i_wire_start),
    .i_wire_clear      (i_wire_clear),
    .i_wire_mode       (i_wire_mode),
    .i_wire_color0     (i_wire_color0),
    .i_wire_color1     (i_wire_color1),
    .i_wire_length     (i_wire_length),
    .o_wire_data       (o_wire_data),
    .o_wire_data_valid (o_wire_data_valid),
    .i_wire_data_next  (i_wire_data_next),
    .o_wire_busy       (o_wire_busy),
    .o_wire_done       (o_wire_done),
    .o_wire_error      (o_wire_error),
    .o_wire_error_type (o_wire_error_type)
  );

  always #5 i_wire_clock = ~i_wire_clock;

  task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic start_job(input logic [1:0] mode, input logic [31:0] c0,
                           input logic [31:0] c1, input logic [31:0] len);
    @(negedge i_wire_clock);
    i_wire_mode   = mode;
    i_wire_color0 = c0;
    i_wire_color1 = c1;
    i_wire_length = len;
    i_wire_start  = 1'b1;
    @(negedge i_wire_clock);
    i_wire_start  = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge i_wire_clock);
    i_wire_clear = 1'b1;
    @(negedge i_wire_clock);
    i_wire_clear = 1'b0;
  endtask

  // Drive next each negedge and record the word that the following posedge pops
  task automatic collect(input int len, input bit rnd, input string tag);
    got_n = 0;
    for (int cyc = 0; cyc < 2000 && got_n < len; cyc++) begin
      @(negedge i_wire_clock);
      i_wire_data_next = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_wire_data_valid && i_wire_data_next) begin
        got_words[got_n] = o_wire_data;
        got_n++;
      end
    end
    tb_check({tag, "_word_count"}, got_n, len);
  endtask

  initial begin
    int n;
    i_wire_reset     = 1'b1;
    i_wire_start     = 1'b0;
    i_wire_clear     = 1'b0;
    i_wire_mode      = 2'd0;
    i_wire_color0    = '0;
    i_wire_color1    = '0;
    i_wire_length    = '0;
    i_wire_data_next = 1'b0;
    repeat (3) @(negedge i_wire_clock);
    tb_check("rst_valid", o_wire_data_valid, 0);
    tb_check("rst_data", o_wire_data, 0);
    tb_check("rst_flags", {o_wire_busy, o_wire_done, o_wire_error}, 0);
    tb_check("rst_errtype", o_wire_error_type, 0);
    i_wire_reset = 1'b0;

    // next while empty in IDLE must not disturb the FIFO
    @(negedge i_wire_clock);
    i_wire_data_next = 1'b1;
    repeat (3) @(negedge i_wire_clock);
    tb_check("empty_next_count", 32'(dut.fifo_count), 0);
    tb_check("empty_next_valid", o_wire_data_valid, 0);
    i_wire_data_next = 1'b0;

    // Solid, next held high
    start_job(2'd0, 32'hFF102030, 32'h0, 32'd5);
    tb_check("solid_busy", o_wire_busy, 1);
    collect(5, 1'b0, "solid");
    for (int i = 0; i < 5; i++) tb_check($sformatf("solid_w%0d", i), got_words[i], 32'hFF102030);
    tb_check("solid_done_not_early", o_wire_done, 0);
    @(negedge i_wire_clock);
    tb_check("solid_done", o_wire_done, 1);
    tb_check("solid_valid_low", o_wire_data_valid, 0);
    pulse_clear();
    tb_check("solid_clear_idle", {o_wire_busy, o_wire_done, o_wire_error}, 0);

    // Checker, random consumer
    start_job(2'd1, 32'hA, 32'hB, 32'd20);
    collect(20, 1'b1, "checker");
    for (int i = 0; i < 20; i++)
      tb_check($sformatf("checker_w%0d", i), got_words[i], (i >= 8 && i < 16) ? 32'hB : 32'hA);
    i_wire_data_next = 1'b1;
    @(negedge i_wire_clock);
    tb_check("checker_done", o_wire_done, 1);
    pulse_clear();

    // Ramp wrapping past 2^32
    start_job(2'd2, 32'hFFFFFFFE, 32'h0, 32'd4);
    collect(4, 1'b0, "ramp");
    tb_check("ramp_w0", got_words[0], 32'hFFFFFFFE);
    tb_check("ramp_w1", got_words[1], 32'hFFFFFFFF);
    tb_check("ramp_w2", got_words[2], 32'h00000000);
    tb_check("ramp_w3", got_words[3], 32'h00000001);
    @(negedge i_wire_clock);
    tb_check("ramp_done", o_wire_done, 1);
    pulse_clear();
    i_wire_data_next = 1'b0;

    // Parameter and mode errors
    start_job(2'd0, 32'h1, 32'h0, 32'd0);
    tb_check("len0_error", o_wire_error, 1);
    tb_check("len0_type", o_wire_error_type, 1);
    pulse_clear();
    tb_check("len0_clear_error", o_wire_error, 0);
    tb_check("len0_clear_type", o_wire_error_type, 0);
    start_job(2'd3, 32'h1, 32'h0, 32'd5);
    tb_check("mode3_type", o_wire_error_type, 3);
    pulse_clear();
    start_job(2'd3, 32'h1, 32'h0, 32'd0);
    tb_check("prio_type", o_wire_error_type, 1);
    pulse_clear();
    tb_check("prio_clear_idle", {o_wire_busy, o_wire_done, o_wire_error}, 0);

    // Consumer timeout: FIFO fills to 4, then 65535 stalled cycles
    start_job(2'd0, 32'h55, 32'h0, 32'd10);
    n = 0;
    for (int cyc = 0; cyc < 20 && !o_wire_data_valid; cyc++) @(negedge i_wire_clock);
    tb_check("tmo_valid_rises", o_wire_data_valid, 1);
    while (n < 70000 && !o_wire_error) begin
      @(negedge i_wire_clock);
      n++;
      if (n == 10) tb_check("tmo_fifo_full", 32'(dut.fifo_count), 4);
    end
    tb_check("tmo_stall_cycles", n, 65535);
    tb_check("tmo_type", o_wire_error_type, 2);
    pulse_clear();
    tb_check("tmo_clear_valid", o_wire_data_valid, 0);

    // Reset mid-job after three pops, then a fresh short job
    start_job(2'd0, 32'h77, 32'h0, 32'd8);
    collect(3, 1'b0, "midrst");
    @(negedge i_wire_clock);
    i_wire_data_next = 1'b0;
    i_wire_reset     = 1'b1;
    @(negedge i_wire_clock);
    tb_check("midrst_valid", o_wire_data_valid, 0);
    tb_check("midrst_count", 32'(dut.fifo_count), 0);
    i_wire_reset = 1'b0;
    repeat (3) @(negedge i_wire_clock);
    tb_check("midrst_quiet", {o_wire_data_valid, o_wire_busy}, 0);
    start_job(2'd2, 32'h100, 32'h0, 32'd2);
    collect(2, 1'b0, "after_rst");
    tb_check("after_rst_w0", got_words[0], 32'h100);
    tb_check("after_rst_w1", got_words[1], 32'h101);
    @(negedge i_wire_clock);
    tb_check("after_rst_done", o_wire_done, 1);
    tb_check("after_rst_no_extra", o_wire_data_valid, 0);
    i_wire_data_next = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_pixel_source.md
PAINTERENGINE_GPU_PIXEL_SOURCE -- requirements
Module: painterengine_gpu_pixel_source

Interface
REQ-001 SHALL have parameter PARAM_FIFO_DEPTH, default 4, giving output FIFO depth in 32-bit words (power of two, 2..16).
REQ-002 SHALL have port i_wire_clock  input  1  the only clock; all logic on its rising edge.
REQ-003 SHALL have port i_wire_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_wire_start  input  1  one-cycle pulse that launches a job; honoured only in IDLE.
REQ-005 SHALL have port i_wire_clear  input  1  one-cycle pulse that returns DONE or ERROR to IDLE.
REQ-006 SHALL have port i_wire_mode  input  2  pattern: 0 solid, 1 checker, 2 ramp, 3 reserved.
REQ-007 SHALL have port i_wire_color0  input  32  primary ARGB value.
REQ-008 SHALL have port i_wire_color1  input  32  secondary ARGB value (checker only).
REQ-009 SHALL have port i_wire_length  input  32  number of words to produce.
REQ-010 SHALL have port o_wire_data  output  32  FIFO head word, fed to the DMA writer data lane.
REQ-011 SHALL have port o_wire_data_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port i_wire_data_next  input  1  consume strobe from the DMA writer; pops the head in the same cycle.
REQ-013 SHALL have port o_wire_busy  output  1  state is RUN or DRAIN.
REQ-014 SHALL have port o_wire_done  output  1  state is DONE.
REQ-015 SHALL have port o_wire_error  output  1  state is ERROR.
REQ-016 SHALL have port o_wire_error_type  output  3  error code.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE, ERROR.
REQ-018 SHALL, on start in IDLE, latch mode, color0, color1 and length, clear the word index and the timeout counter, and move to RUN the next cycle.
REQ-019 SHALL, on start with length==0, go to ERROR with code 1 (param); with mode==3, go to ERROR with code 3 (mode). The param check takes priority.
REQ-020 SHALL, in RUN, push exactly one word per cycle when count<DEPTH or when a pop occurs in the same cycle.
REQ-021 SHALL generate word index i as follows: solid = color0; checker = (i[3]) ? color1 : color0; ramp = color0 + i, modulo 2^32.
REQ-022 SHALL increment the 32-bit word index per push and move RUN->DRAIN on the cycle of the push with i==length-1.
REQ-023 SHALL move DRAIN->DONE on the cycle the FIFO becomes empty after a pop.
REQ-024 SHALL ignore i_wire_data_next while the FIFO is empty; it causes no pop, no underflow and no count change.
REQ-025 SHALL, on simultaneous push and pop, leave the count unchanged and keep data order FIFO-exact.
REQ-026 SHALL drive o_wire_data from the head register with zero latency from valid; data stays stable while valid is high and no pop occurs.
REQ-027 SHALL keep a 16-bit timeout counter that increments in RUN or DRAIN when valid is high and next is low, and clears on any pop.
REQ-028 SHALL, when the timeout counter reaches 65535, go to ERROR with code 2 (consumer timeout).
REQ-029 SHALL leave DONE and ERROR only on i_wire_clear, which empties the FIFO and enters IDLE.
REQ-030 SHALL treat clear in any other state, and start outside IDLE, as no effect.

Reset
REQ-031 SHALL, on reset, put state=IDLE, count=0, read and write pointers=0, index=0, timeout=0 and error_type=0.
REQ-032 SHALL drive outputs to 0 during and after reset: o_wire_data, o_wire_data_valid, busy, done, error and error_type.
REQ-033 SHALL, on reset mid-job, discard the FIFO contents; no further valid is asserted until a new start.

Structure
REQ-034 SHALL take state encodings, error codes (0 ok, 1 param, 2 timeout, 3 mode) and mode codes from the shared package painterengine_gpu_pkg.
REQ-035 SHALL instantiate the FIFO as sub-module painterengine_gpu_sync_fifo, with WIDTH=32, DEPTH parameters and push/pop/full/empty/count ports.

Verification
REQ-036 SHALL check: solid, color0=0xFF102030, length=5, next held high -> five words 0xFF102030, valid low afterwards, done one cycle after the last pop.
REQ-037 SHALL check: checker, color0=0xA, color1=0xB, length=20, next random -> words 0-7=0xA, 8-15=0xB, 16-19=0xA, in order, none lost.
REQ-038 SHALL check: ramp, color0=0xFFFFFFFE, length=4 -> 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-039 SHALL check: length=0 -> error=1 and error_type=1 the next cycle; mode=3 -> error_type=3; clear -> IDLE.
REQ-040 SHALL check: length=10, next held low -> FIFO fills at 4, then error_type=2 after 65535 stalled cycles.
REQ-041 SHALL check: reset asserted after 3 pops of a length-8 job -> valid=0 and count=0; a new start with length=2 yields exactly 2 words.
